mul_share_sched: RTL

- Scheduler that shares one repeated-addition multiplier datapath (A reg, B down-counter, P accumulator, B==0 flag) between NREQ requesters.
- Arbitrates round-robin and captures the winner's operands.
- Sequences the datapath load/clear/accumulate/decrement strobes and returns the product to the winning requester with a one-cycle valid.
- Sits between the client blocks and the multiplier datapath, replacing a single-user start/done controller.

---
 rtl/mul_share_sched.sv | 117 +++++++++++
 1 files changed

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one repeated-addition multiplier datapath
// between NREQ requesters; sequences the datapath strobes and returns products.
module mul_share_sched #(
   parameter int NREQ = 4,
   parameter int W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] opa,
   input  logic [NREQ*W-1:0] opb,
   output logic [NREQ-1:0]   gnt,
   output logic              busy,
   output logic              LdA,
   output logic              LdB,
   output logic              clrP,
   output logic              LdP,
   output logic              decB,
   output logic [W-1:0]      bus_out,
   input  logic              eqz,
   input  logic [W-1:0]      prod_in,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [W-1:0]      rsp_data
);

   localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ACC, DONE} state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] rr, sel, pick, sel_inc;
   logic          found;
   logic [W-1:0]  a_reg, b_reg;

   // First requester at or above the round-robin pointer, wrapping around.
   always_comb begin
      int j;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         j = int'(rr) + i;
         if (j >= NREQ) j = j - NREQ;
         if (!found && req[j]) begin
            found = 1'b1;
            pick  = SW'(j);
         end
      end
   end

   assign sel_inc = (sel == SW'(NREQ - 1)) ? '0 : sel + SW'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         rr    <= '0;
         sel   <= '0;
         a_reg <= '0;
         b_reg <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && found) begin
            sel   <= pick;
            a_reg <= opa[int'(pick)*W +: W];
            b_reg <= opb[int'(pick)*W +: W];
         end
         if (state == DONE) rr <= sel_inc;
      end
   end

   // Strobes are decoded from state; the eqz cycle in ACC does not accumulate.
   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      LdA       = 1'b0;
      LdB       = 1'b0;
      clrP      = 1'b0;
      LdP       = 1'b0;
      decB      = 1'b0;
      bus_out   = '0;
      rsp_data  = '0;
      gnt       = '0;
      rsp_valid = '0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (found) state_nxt = LOAD_A;
         end
         LOAD_A: begin
            LdA       = 1'b1;
            bus_out   = a_reg;
            state_nxt = LOAD_B;
            for (int i = 0; i < NREQ; i++) gnt[i] = (sel == SW'(i));
         end
         LOAD_B: begin
            LdB       = 1'b1;
            clrP      = 1'b1;
            bus_out   = b_reg;
            state_nxt = ACC;
         end
         ACC: begin
            if (eqz) begin
               state_nxt = DONE;
            end else begin
               LdP  = 1'b1;
               decB = 1'b1;
            end
         end
         DONE: begin
            rsp_data  = prod_in;
            state_nxt = IDLE;
            for (int i = 0; i < NREQ; i++) rsp_valid[i] = (sel == SW'(i));
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
